tl_a_queue: RTL and testbench
=============================

# tl_a_queue

Parametrised TileLink A-channel buffering queue: a circular FIFO of DEPTH entries carrying opcode, param, size, source, address, mask, data and corrupt, with optional flow-through and pipe modes and an occupancy count. It is the general replacement for fixed two-entry A-channel queues, sitting between TileLink masters and crossbars/adapters wherever decoupling or rate matching is needed.

## Interface
- DEPTH, 2, number of entries; any integer ≥ 1 (not restricted to powers of two)
- SOURCE_W, 4, source ID width
- ADDR_W, 32, address width
- DATA_W, 64, data width; multiple of 8
- FLOW, 0, 1 = empty queue forwards enq to deq in the same cycle
- PIPE, 0, 1 = full queue accepts enq in the same cycle a deq occurs
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- io_enq_valid  input  1  producer offers a beat
- io_enq_ready  output  1  queue accepts the beat this cycle
- io_enq_bits_opcode / _param  input  3 each  TL A opcode / param
- io_enq_bits_size  input  4  log2 transfer size
- io_enq_bits_source  input  SOURCE_W  source ID
- io_enq_bits_address  input  ADDR_W  byte address
- io_enq_bits_mask  input  DATA_W/8  byte lane mask
- io_enq_bits_data  input  DATA_W  payload
- io_enq_bits_corrupt  input  1  corrupt flag
- io_deq_valid  output  1  head entry available
- io_deq_ready  input  1  consumer takes the head
- io_deq_bits_*  output  same widths as enq  head entry fields
- io_count  output  clog2(DEPTH+1)  entries currently held

## Operation
- State: enq_ptr, deq_ptr (clog2(DEPTH) bits, 1 bit minimum), maybe_full; storage array of DEPTH × packed A-beat.
- ptr_match = enq_ptr == deq_ptr; empty = ptr_match & ~maybe_full; full = ptr_match & maybe_full.
- Base handshake: io_enq_ready = ~full; io_deq_valid = ~empty; do_enq = enq_valid & enq_ready; do_deq = deq_valid & deq_ready.
- do_enq: write all fields, including corrupt, at enq_ptr; enq_ptr advances. do_deq: deq_ptr advances.
- Pointer advance: ptr == DEPTH-1 → 0, else ptr+1 (explicit wrap for non-power-of-two DEPTH). DEPTH=1: pointers constant 0.
- maybe_full <= do_enq whenever do_enq != do_deq; unchanged otherwise.
- io_deq_bits_* = storage[deq_ptr], combinational read.
- FLOW=1 and empty: io_deq_valid = io_enq_valid; deq bits = enq bits; if deq_ready the beat bypasses — no write, no pointer or maybe_full change. If deq_ready=0 the beat is stored normally.
- PIPE=1: io_enq_ready = ~full | io_deq_ready; a full queue with simultaneous enq and deq writes the slot freed by deq, maybe_full stays 1.
- io_count = ptr_match ? (maybe_full ? DEPTH : 0) : (enq_ptr > deq_ptr ? enq_ptr - deq_ptr : DEPTH + enq_ptr - deq_ptr).
- No field is interpreted; multibeat bursts are queued beat by beat.

## Timing
- Reset: enq_ptr=deq_ptr=0, maybe_full=0 → io_enq_ready=1, io_deq_valid=0 (FLOW=1: follows io_enq_valid), io_count=0. Storage not reset; deq bits undefined while deq_valid=0.
- Reset asserted mid-operation flushes all contents on the next edge; in-flight beats lost.
- Latency enq→deq: 1 cycle (0 with FLOW bypass when empty).
- Throughput: 1 beat/cycle sustained when not full; full queue with PIPE=0 stalls enq one cycle per deq.
- io_enq_ready and io_deq_valid never depend combinationally on their own valid/ready partner except FLOW (deq_valid←enq_valid) and PIPE (enq_ready←deq_ready).
- Simultaneous enq/deq when neither empty nor full: count unchanged, both pointers advance.

## Test plan
- DEPTH=2 fill/drain: enq sources 1,2 with deq_ready=0 → count 2, enq_ready=0; enq source 3 held; deq_ready=1 → sources 1,2,3 out in order, count back to 0.
- DEPTH=3 wrap: 10 beats, addresses 0x1000+0x40·i, random deq_ready → all in order, pointers pass 2→0, count never >3.
- FLOW=1 empty, enq_valid & deq_ready, data 0xDEADBEEF → same-cycle deq of 0xDEADBEEF, count stays 0; with deq_ready=0 → stored, count 1.
- PIPE=1 DEPTH=2 full, enq_valid & deq_ready → enq_ready=1, head dequeued, new beat accepted, count stays 2.
- corrupt=1, mask=0x0F on beat 2 of 4 → emerges on beat 2 only with identical mask.
- Reset asserted with count 2 → next cycle deq_valid=0, enq_ready=1, count 0.

Source files
------------

// File: rtl/tl_a_queue.sv
// TileLink A-channel buffering queue: circular FIFO of DEPTH beats with optional
// flow-through (empty bypass) and pipe (full accept-on-dequeue) modes.
module tl_a_queue #(
    parameter int DEPTH    = 2,
    parameter int SOURCE_W = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int FLOW     = 0,
    parameter int PIPE     = 0,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_enq_valid,
    output logic                  io_enq_ready,
    input  logic [2:0]            io_enq_bits_opcode,
    input  logic [2:0]            io_enq_bits_param,
    input  logic [3:0]            io_enq_bits_size,
    input  logic [SOURCE_W-1:0]   io_enq_bits_source,
    input  logic [ADDR_W-1:0]     io_enq_bits_address,
    input  logic [DATA_W/8-1:0]   io_enq_bits_mask,
    input  logic [DATA_W-1:0]     io_enq_bits_data,
    input  logic                  io_enq_bits_corrupt,
    output logic                  io_deq_valid,
    input  logic                  io_deq_ready,
    output logic [2:0]            io_deq_bits_opcode,
    output logic [2:0]            io_deq_bits_param,
    output logic [3:0]            io_deq_bits_size,
    output logic [SOURCE_W-1:0]   io_deq_bits_source,
    output logic [ADDR_W-1:0]     io_deq_bits_address,
    output logic [DATA_W/8-1:0]   io_deq_bits_mask,
    output logic [DATA_W-1:0]     io_deq_bits_data,
    output logic                  io_deq_bits_corrupt,
    output logic [CNT_W-1:0]      io_count
);

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [3:0]          size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W/8-1:0] mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } beat_t;

    beat_t            ram [DEPTH];
    beat_t            enq_beat, deq_beat;
    logic [PTR_W-1:0] enq_ptr, deq_ptr;
    logic             maybe_full;
    logic             ptr_match, empty, full, bypass;
    logic             do_enq, do_deq, wr_en, rd_en;

    // Explicit wrap so non-power-of-two depths never index past the last slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ptr_match = enq_ptr == deq_ptr;
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;
    assign bypass    = (FLOW != 0) & empty;

    assign io_enq_ready = ~full | ((PIPE != 0) & io_deq_ready);
    assign io_deq_valid = ~empty | (bypass & io_enq_valid);

    assign do_enq = io_enq_valid & io_enq_ready;
    assign do_deq = io_deq_valid & io_deq_ready;
    // A bypassed beat leaves storage untouched; a deq from an empty queue can only be a bypass.
    assign wr_en  = do_enq & ~(bypass & io_deq_ready);
    assign rd_en  = do_deq & ~empty;

    assign enq_beat = '{opcode:  io_enq_bits_opcode,
                        param:   io_enq_bits_param,
                        size:    io_enq_bits_size,
                        source:  io_enq_bits_source,
                        address: io_enq_bits_address,
                        mask:    io_enq_bits_mask,
                        data:    io_enq_bits_data,
                        corrupt: io_enq_bits_corrupt};

    assign deq_beat = bypass ? enq_beat : ram[deq_ptr];

    assign io_deq_bits_opcode  = deq_beat.opcode;
    assign io_deq_bits_param   = deq_beat.param;
    assign io_deq_bits_size    = deq_beat.size;
    assign io_deq_bits_source  = deq_beat.source;
    assign io_deq_bits_address = deq_beat.address;
    assign io_deq_bits_mask    = deq_beat.mask;
    assign io_deq_bits_data    = deq_beat.data;
    assign io_deq_bits_corrupt = deq_beat.corrupt;

    always_ff @(posedge clock) begin
        if (wr_en) ram[enq_ptr] <= enq_beat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (wr_en) enq_ptr <= ptr_inc(enq_ptr);
            if (rd_en) deq_ptr <= ptr_inc(deq_ptr);
            if (wr_en != rd_en) maybe_full <= wr_en;
        end
    end

    always_comb begin
        if (ptr_match)
            io_count = maybe_full ? CNT_W'(DEPTH) : '0;
        else if (enq_ptr > deq_ptr)
            io_count = CNT_W'(enq_ptr) - CNT_W'(deq_ptr);
        else
            io_count = CNT_W'(DEPTH) + CNT_W'(enq_ptr) - CNT_W'(deq_ptr);
    end

endmodule

// File: tb/tb_tl_a_queue.sv
// Bench for tl_a_queue: four configurations share one directed stimulus stream and are
// each checked every cycle against a list-based queue model, plus literal spot checks.
module tb_tl_a_queue;

    localparam int NI = 4;
    localparam int DEP [NI] = '{2, 3, 2, 2};
    localparam int FLW [NI] = '{0, 0, 1, 0};
    localparam int PIP [NI] = '{0, 0, 0, 1};
    localparam int LOGN = 128;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [3:0]  source;
        logic [31:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
    } beat_t;

    logic clock = 1'b0;
    logic reset;
    logic enq_valid, deq_ready;
    beat_t in_b;

    logic [NI-1:0]       enq_rdy, deq_vld;
    logic [NI-1:0][1:0]  cnt;
    beat_t [NI-1:0]      deq_b;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    beat_t ml [NI][0:3];
    int    mlen [NI];
    beat_t logb [NI][0:LOGN-1];
    int    log_n [NI];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_q
        logic [2:0]  op, pa;
        logic [3:0]  sz, src;
        logic [31:0] ad;
        logic [7:0]  mk;
        logic [63:0] dt;
        logic        cr;
        tl_a_queue #(.DEPTH(DEP[g]), .SOURCE_W(4), .ADDR_W(32), .DATA_W(64),
                     .FLOW(FLW[g]), .PIPE(PIP[g])) u_q (
            .clock(clock), .reset(reset),
            .io_enq_valid(enq_valid), .io_enq_ready(enq_rdy[g]),
            .io_enq_bits_opcode(in_b.opcode), .io_enq_bits_param(in_b.param),
            .io_enq_bits_size(in_b.size), .io_enq_bits_source(in_b.source),
            .io_enq_bits_address(in_b.address), .io_enq_bits_mask(in_b.mask),
            .io_enq_bits_data(in_b.data), .io_enq_bits_corrupt(in_b.corrupt),
            .io_deq_valid(deq_vld[g]), .io_deq_ready(deq_ready),
            .io_deq_bits_opcode(op), .io_deq_bits_param(pa),
            .io_deq_bits_size(sz), .io_deq_bits_source(src),
            .io_deq_bits_address(ad), .io_deq_bits_mask(mk),
            .io_deq_bits_data(dt), .io_deq_bits_corrupt(cr),
            .io_count(cnt[g]));
        assign deq_b[g] = {op, pa, sz, src, ad, mk, dt, cr};
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [3:0] s, input logic [31:0] a);
        beat_t b;
        b.opcode  = 3'd0;
        b.param   = 3'd0;
        b.size    = 4'd3;
        b.source  = s;
        b.address = a;
        b.mask    = 8'hFF;
        b.data    = {a, ~a};
        b.corrupt = 1'b0;
        return b;
    endfunction

    // Model: each queue is an ordered list; head at index 0.
    always @(negedge clock) begin : cmp
        int L;
        logic emp, e_er, e_dv, efire, dfire;
        beat_t e_b;
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                L    = mlen[i];
                emp  = (L == 0);
                e_er = (L < DEP[i]) || (PIP[i] != 0 && deq_ready);
                e_dv = !emp || (FLW[i] != 0 && enq_valid);
                e_b  = emp ? in_b : ml[i][0];
                chk($sformatf("u%0d_enq_ready", i), 128'(enq_rdy[i]), 128'(e_er));
                chk($sformatf("u%0d_deq_valid", i), 128'(deq_vld[i]), 128'(e_dv));
                chk($sformatf("u%0d_count", i), 128'(cnt[i]), 128'(L));
                if (e_dv) chk($sformatf("u%0d_deq_bits", i), 128'(deq_b[i]), 128'(e_b));
                if (reset) begin
                    mlen[i] = 0;
                end else begin
                    efire = enq_valid && e_er;
                    dfire = e_dv && deq_ready;
                    if (dfire && log_n[i] < LOGN) begin
                        logb[i][log_n[i]] = e_b;
                        log_n[i]++;
                    end
                    if (!(emp && efire && dfire)) begin
                        if (dfire) begin
                            for (int j = 0; j < 3; j++) ml[i][j] = ml[i][j+1];
                            L--;
                        end
                        if (efire) begin
                            ml[i][L] = in_b;
                            L++;
                        end
                    end
                    mlen[i] = L;
                end
            end
        end
    end

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int k, t, base;
        logic acc;
        logic [15:0] pat;
        for (int i = 0; i < NI; i++) begin
            mlen[i]  = 0;
            log_n[i] = 0;
        end
        reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; in_b = '0;
        cyc;
        chk_en = 1'b1;
        cyc;
        reset = 1'b0;

        // Fill / drain on the DEPTH=2 queue; pipe queue exercised by the same stream.
        enq_valid = 1'b1; in_b = mk_beat(4'd1, 32'h100); cyc;
        in_b = mk_beat(4'd2, 32'h104); cyc;
        in_b = mk_beat(4'd3, 32'h108); #1;
        chk("fill_count", 128'(cnt[0]), 128'd2);
        chk("fill_enq_ready", 128'(enq_rdy[0]), 128'd0);
        cyc;
        deq_ready = 1'b1; #1;
        chk("pipe_enq_ready", 128'(enq_rdy[3]), 128'd1);
        chk("pipe_count", 128'(cnt[3]), 128'd2);
        cyc;
        chk("pipe_count_after", 128'(cnt[3]), 128'd2);
        chk("pipe_head", 128'(deq_b[3].source), 128'd2);
        chk("fill_enq_ready_again", 128'(enq_rdy[0]), 128'd1);
        cyc;
        enq_valid = 1'b0;
        repeat (4) cyc;
        chk("drain_count", 128'(cnt[0]), 128'd0);
        chk("drain_n", 128'(log_n[0]), 128'd3);
        chk("drain_src0", 128'(logb[0][0].source), 128'd1);
        chk("drain_src1", 128'(logb[0][1].source), 128'd2);
        chk("drain_src2", 128'(logb[0][2].source), 128'd3);

        // Wrap on the DEPTH=3 queue with an irregular consumer.
        pat = 16'b1011_0010_1110_0101;
        k = 0;
        base = log_n[1];
        for (int i = 0; i < 10; i++) begin
            in_b = mk_beat(4'(i), 32'h1000 + 32'h40 * i);
            enq_valid = 1'b1;
            t = 0;
            acc = 1'b0;
            while (!acc && t < 20) begin
                deq_ready = pat[k % 16];
                k++;
                #1;
                acc = enq_rdy[1];
                cyc;
                t++;
            end
            chk($sformatf("wrap_accept_%0d", i), 128'(acc), 128'd1);
        end
        enq_valid = 1'b0; deq_ready = 1'b1;
        repeat (5) cyc;
        for (int i = 0; i < 10; i++)
            chk($sformatf("wrap_addr_%0d", i), 128'(logb[1][base + i].address),
                128'(32'h1000 + 32'h40 * i));

        // Corrupt and narrow mask on beat 2 of a 4-beat burst.
        base = log_n[0];
        for (int i = 0; i < 4; i++) begin
            in_b = mk_beat(4'd5, 32'h2000 + 32'h8 * i);
            in_b.mask    = (i == 1) ? 8'h0F : 8'hFF;
            in_b.corrupt = (i == 1);
            enq_valid = 1'b1;
            cyc;
        end
        enq_valid = 1'b0;
        repeat (3) cyc;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst_corrupt_%0d", i), 128'(logb[0][base + i].corrupt),
                128'(i == 1));
            chk($sformatf("burst_mask_%0d", i), 128'(logb[0][base + i].mask),
                (i == 1) ? 128'h0F : 128'hFF);
        end

        // Flow-through on the empty FLOW queue.
        in_b = mk_beat(4'd7, 32'h3000);
        in_b.data = 64'hDEADBEEF;
        enq_valid = 1'b1; deq_ready = 1'b1; #1;
        chk("flow_valid", 128'(deq_vld[2]), 128'd1);
        chk("flow_data", 128'(deq_b[2].data), 128'hDEADBEEF);
        chk("flow_count", 128'(cnt[2]), 128'd0);
        cyc;
        in_b.data = 64'hCAFEF00D;
        deq_ready = 1'b0; #1;
        chk("flow_count_after", 128'(cnt[2]), 128'd0);
        chk("flow_valid_stall", 128'(deq_vld[2]), 128'd1);
        cyc;
        enq_valid = 1'b0; #1;
        chk("flow_stored_count", 128'(cnt[2]), 128'd1);
        chk("flow_stored_data", 128'(deq_b[2].data), 128'hCAFEF00D);
        deq_ready = 1'b1;
        repeat (4) cyc;

        // Reset with two beats held flushes everything.
        deq_ready = 1'b0; enq_valid = 1'b1;
        in_b = mk_beat(4'd8, 32'h4000); cyc;
        in_b = mk_beat(4'd9, 32'h4004); cyc;
        enq_valid = 1'b0; #1;
        chk("pre_reset_count", 128'(cnt[0]), 128'd2);
        reset = 1'b1;
        cyc;
        reset = 1'b0; #1;
        chk("post_reset_valid", 128'(deq_vld[0]), 128'd0);
        chk("post_reset_ready", 128'(enq_rdy[0]), 128'd1);
        chk("post_reset_count", 128'(cnt[0]), 128'd0);
        repeat (3) cyc;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
